// File: rtl/text_mode_pkg.sv
// Shared text-mode geometry for the glyph-lookup path: screen size, glyph size and derived field widths.
package text_mode_pkg;

  localparam int COLUMNS     = 80;
  localparam int ROWS        = 30;
  localparam int CHAR_W      = 8;
  localparam int CHAR_H      = 16;

  localparam int TEXT_ADDR_W = $clog2(COLUMNS * ROWS);
  localparam int CELL_X_W    = $clog2(CHAR_W);
  localparam int CELL_Y_W    = $clog2(CHAR_H);
  localparam int COL_W       = $clog2(COLUMNS);
  localparam int ROW_W       = $clog2(ROWS);

  localparam int SCREEN_W    = COLUMNS * CHAR_W;
  localparam int SCREEN_H    = ROWS * CHAR_H;

  // Per-pixel side information that travels alongside the buffer/font lookups.
  typedef struct packed {
    logic                valid;
    logic                cursor;
    logic [CELL_X_W-1:0] cell_x;
    logic [CELL_Y_W-1:0] cell_y;
  } cell_info_t;

endpackage

// File: rtl/cursor_blink_timer.sv
// Frame counter driving the cursor blink phase; built only when CURSOR_BLINK_EN is defined.
module cursor_blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_start,
  output logic blink_phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] frame_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (frame_count == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_count <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/text_pixel_renderer.sv
// Five-stage text-mode pixel pipeline: raster -> text buffer -> font ROM -> monochrome pixel.
// Optional cursor blink overlay is enabled with the CURSOR_BLINK_EN macro.
module text_pixel_renderer
  import text_mode_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic                   CLOCK_150,
  input  logic                   reset,
  input  logic [10:0]            pixel_x,
  input  logic [9:0]             pixel_y,
  input  logic                   pixel_active,
  input  logic                   frame_start,
  output logic [TEXT_ADDR_W-1:0] text_addr,
  input  logic [7:0]             text_data,
  output logic [7:0]             font_character,
  output logic [CELL_X_W-1:0]    font_cell_x,
  output logic [CELL_Y_W-1:0]    font_cell_y,
  input  logic                   font_pixel,
  input  logic [COL_W-1:0]       cursor_col,
  input  logic [ROW_W-1:0]       cursor_row,
  output logic                   pixel_out,
  output logic                   pixel_out_active
);

  logic             in_valid;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             cursor_hit;

  assign in_valid = pixel_active
                 && (pixel_x < 11'(SCREEN_W))
                 && (pixel_y < 10'(SCREEN_H));
  assign col = COL_W'(pixel_x >> CELL_X_W);
  assign row = ROW_W'(pixel_y >> CELL_Y_W);

`ifdef CURSOR_BLINK_EN
  logic blink_phase;

  cursor_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk         (CLOCK_150),
    .reset       (reset),
    .frame_start (frame_start),
    .blink_phase (blink_phase)
  );

  assign cursor_hit = blink_phase && (col == cursor_col) && (row == cursor_row);
`else
  logic unused_cursor_inputs;
  assign unused_cursor_inputs = ^{frame_start, cursor_col, cursor_row} ^ (BLINK_FRAMES > 0);
  assign cursor_hit = 1'b0;
`endif

  logic [TEXT_ADDR_W-1:0] addr_next;
  cell_info_t             info_next;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    addr_next = '0;
    info_next = '0;
    if (in_valid) begin
      addr_next        = TEXT_ADDR_W'(row) * TEXT_ADDR_W'(COLUMNS) + TEXT_ADDR_W'(col);
      info_next.valid  = 1'b1;
      info_next.cursor = cursor_hit;
      info_next.cell_x = pixel_x[CELL_X_W-1:0];
      info_next.cell_y = pixel_y[CELL_Y_W-1:0];
    end
  end

  cell_info_t s1_info, s2_info;
  logic       s3_valid, s3_cursor, s4_valid, s4_cursor;

  // NOTE: sequential state uses non-blocking assignments so every stage samples its predecessor's pre-edge value.
  // NOTE: the pipeline holds only flops (no memory arrays), so all of it clears on reset and in-flight pixels vanish at once.
  always_ff @(posedge CLOCK_150) begin
    if (reset) begin
      text_addr        <= '0;
      s1_info          <= '0;
      s2_info          <= '0;
      font_character   <= '0;
      font_cell_x      <= '0;
      font_cell_y      <= '0;
      s3_valid         <= 1'b0;
      s3_cursor        <= 1'b0;
      s4_valid         <= 1'b0;
      s4_cursor        <= 1'b0;
      pixel_out        <= 1'b0;
      pixel_out_active <= 1'b0;
    end else begin
      text_addr      <= addr_next;
      s1_info        <= info_next;
      s2_info        <= s1_info;
      // text_data answers the address issued one stage earlier, so it is gated by that stage's valid.
      font_character <= s2_info.valid ? text_data : 8'h00;
      font_cell_x    <= s2_info.cell_x;
      font_cell_y    <= s2_info.cell_y;
      s3_valid       <= s2_info.valid;
      s3_cursor      <= s2_info.cursor;
      s4_valid       <= s3_valid;
      s4_cursor      <= s3_cursor;
      pixel_out        <= (font_pixel ^ s4_cursor) & s4_valid;
      pixel_out_active <= s4_valid;
    end
  end

endmodule
